// File: rtl/maze_pkg.sv
// Shared types and PS/2 set-2 scancode constants for the maze game input path.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_PAUSE
    } ps2dec_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;

    // Bytes still to swallow after the leading E1 of the Pause sequence
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

endpackage

// File: rtl/ps2_move_decoder_lookup.sv
// Maps a scancode byte to a direction; arrow codes only in extended context,
// WASD codes only in plain context and only when enabled.
module ps2_code_lookup
    import maze_pkg::*;
(
    input  logic [7:0] code_i,
    input  logic       ext_i,
    input  logic       wasd_en_i,
    output logic       hit_o,
    output dir_t       dir_o
);

    always_comb begin
        hit_o = 1'b0;
        dir_o = UP;
        if (ext_i) begin
            case (code_i)
                SC_UP:    begin hit_o = 1'b1; dir_o = UP;    end
                SC_DOWN:  begin hit_o = 1'b1; dir_o = DOWN;  end
                SC_LEFT:  begin hit_o = 1'b1; dir_o = LEFT;  end
                SC_RIGHT: begin hit_o = 1'b1; dir_o = RIGHT; end
                default:  ;
            endcase
        end else if (wasd_en_i) begin
            case (code_i)
                SC_W:    begin hit_o = 1'b1; dir_o = UP;    end
                SC_S:    begin hit_o = 1'b1; dir_o = DOWN;  end
                SC_A:    begin hit_o = 1'b1; dir_o = LEFT;  end
                SC_D:    begin hit_o = 1'b1; dir_o = RIGHT; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 scancode stream to maze move pulses: prefix FSM, per-source held flags,
// prefix timeout and registered outputs.
module ps2_move_decoder
    import maze_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000,
    parameter bit ENABLE_WASD    = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic [3:0] key_held,
    output logic       seq_error
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    ps2dec_state_t state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]    pcnt_q, pcnt_d;
    logic [3:0]    arrow_q, arrow_d;
    logic [3:0]    wasd_q, wasd_d;
    logic [3:0]    held_q, held_d;
    logic          mv_q, mv_d;
    dir_t          dir_q, dir_d;
    logic          serr_q, serr_d;

    logic ext;
    logic hit;
    dir_t ldir;
    logic do_make, do_brk;

    assign ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);

    ps2_code_lookup u_lookup (
        .code_i    (received_data),
        .ext_i     (ext),
        .wasd_en_i (ENABLE_WASD),
        .hit_o     (hit),
        .dir_o     (ldir)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        pcnt_d  = pcnt_q;
        arrow_d = arrow_q;
        wasd_d  = wasd_q;
        mv_d    = 1'b0;
        dir_d   = dir_q;
        serr_d  = 1'b0;
        do_make = 1'b0;
        do_brk  = 1'b0;

        // A strobe takes priority over an expiring timeout in the same cycle
        if (received_data_en) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (received_data == SC_EXT)        state_d = ST_EXT;
                    else if (received_data == SC_BRK)   state_d = ST_BRK;
                    else if (received_data == SC_PAUSE) begin
                        state_d = ST_PAUSE;
                        pcnt_d  = PAUSE_TAIL;
                    end else                            do_make = 1'b1;
                end
                ST_EXT: begin
                    if (received_data == SC_BRK) state_d = ST_EXT_BRK;
                    else begin
                        do_make = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    do_brk  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_PAUSE: begin
                    pcnt_d = pcnt_q - 3'd1;
                    if (pcnt_q == 3'd1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
                pcnt_d  = '0;
                serr_d  = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end

        // A pulse only when neither source already holds this direction
        if (do_make && hit) begin
            if (ext) begin
                if (!arrow_q[ldir]) begin
                    arrow_d[ldir] = 1'b1;
                    mv_d          = !held_q[ldir];
                end
            end else if (!wasd_q[ldir]) begin
                wasd_d[ldir] = 1'b1;
                mv_d         = !held_q[ldir];
            end
        end

        if (do_brk && hit) begin
            if (ext) arrow_d[ldir] = 1'b0;
            else     wasd_d[ldir]  = 1'b0;
        end

        if (mv_d) dir_d = ldir;
        held_d = arrow_d | wasd_d;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
            pcnt_q  <= '0;
            arrow_q <= '0;
            wasd_q  <= '0;
            held_q  <= '0;
            mv_q    <= 1'b0;
            dir_q   <= UP;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            pcnt_q  <= pcnt_d;
            arrow_q <= arrow_d;
            wasd_q  <= wasd_d;
            held_q  <= held_d;
            mv_q    <= mv_d;
            dir_q   <= dir_d;
            serr_q  <= serr_d;
        end
    end

    assign move_valid = mv_q;
    assign move_dir   = dir_q;
    assign key_held   = held_q;
    assign seq_error  = serr_q;

endmodule
